mod_counter_chain: RTL and testbench
====================================

Name: mod_counter_chain

Overview:
Parametrised cascade of CH modulo counters, each N bits wide, for the timing generator. It provides per-stage runtime modulus, up/down direction, synchronous parallel load, per-stage carry outputs and a registered full-chain wrap pulse. A typical use is a pixel/line/frame counter chain where stage k+1 advances only on the carry of stage k.

Parameters:
N, 8, width of each counter stage in bits
CH, 2, number of cascaded stages (CH >= 1); stage 0 is least significant

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-low reset
enable  in  1  advance request for stage 0
load  in  1  synchronous parallel load of all stages
dir  in  1  count direction: 0 = up, 1 = down
modul  in  CH*N  per-stage modulus; stage k at [k*N +: N]
load_val  in  CH*N  per-stage load value; same packing
q_out  out  CH*N  per-stage count, registered; same packing
c_out  out  CH  per-stage carry/borrow, combinational from registers and inputs
wrap_out  out  1  registered one-cycle pulse after the last stage's carry

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Priority per clock edge: reset low > load > normal counting.
- Reset (reset=0 at an edge): q_out = 0 for all stages, and wrap_out = 0. c_out is 0 while reset is low. Reset applied mid-count overrides load and enable in the same cycle.
- Modulus M = modul[k]:
  - Stage counts 0..M-1.
  - M = 0 means full range 0..2^N-1.
  - M = 1 holds at 0 and carries on every advance.
- Advance chain: adv[0] = enable & ~load. adv[k] = c_out[k-1] for k >= 1.
- Terminal condition:
  - Up: q >= M-1. For M=0, q = 2^N-1.
  - Down: q == 0.
- c_out[k] = adv[k] & terminal[k] & reset & ~load. It is purely combinational, so there is no pipeline delay along the chain.
- Next state when adv[k] = 1:
  - Up, terminal: q goes to 0.
  - Up, not terminal: q + 1.
  - Down, q == 0: q goes to M-1. For M=0, 2^N-1.
  - Down, q > M-1 (after a modulus decrease): q goes to M-1, no carry.
  - Down, otherwise: q - 1.
- When adv[k] = 0, the stage holds.
- Out-of-range values (q >= M after a modulus change or a load) self-correct on the next advance as defined above. No values are clamped at load time.
- load = 1: every stage takes load_val[k] at the edge, regardless of enable. All c_out are 0 in that cycle and wrap_out is 0 on the following cycle.
- dir and modul are sampled every cycle. A change takes effect on the next advance; counts already held are not altered.
- wrap_out: registered copy of c_out[CH-1]. It is high exactly one cycle after the cycle in which the entire chain wrapped (up) or borrowed (down).
- Arithmetic is modulo 2^N per stage; no stage ever exceeds N bits.
- Latency: q_out updates one cycle after an enabled edge. c_out is valid in the same cycle as the terminal state. wrap_out lags c_out[CH-1] by 1 cycle.

Test Plan:
1. Reset: N=8, CH=2, enable=1, modul={3,5}, reset=0 for 3 cycles -> q_out=0, c_out=0, wrap_out=0 every cycle. Releasing reset=1 -> q_out[7:0]=1 after the first edge.
2. Up chain: stage0 M=5, stage1 M=3, enable=1, dir=0 for 15 cycles from 0.
   - q0 sequence is 0,1,2,3,4,0…
   - c_out[0] is high when q0=4.
   - q1 increments on each q0 wrap.
   - c_out[1] is high in the cycle with q0=4, q1=2.
   - wrap_out is high on cycle 16, and q_out returns to (0,0).
3. Down chain: same moduli, dir=1 from (0,0), enable=1.
   - First cycle: c_out=2'b11; the next state is q0=4, q1=2, and wrap_out is high the next cycle.
   - After that, q0 steps 4,3,2,1,0 and q1 decrements on each q0 borrow.
4. Gated enable: enable toggles every 5 cycles, dir=0, M0=200 -> q0 advances only during enabled cycles, 5 counts per 10 cycles. q0=199 followed by an enabled edge gives 0 with c_out[0]=1.
5. Load priority: during counting with enable=1, assert load=1 with load_val=(stage1=1, stage0=3) while q0 is terminal -> next q_out=(1,3), c_out=0 in the load cycle, and wrap_out=0 in the next cycle.
6. Modulus edge cases (three separate sub-tests):
   - q0=150, M0 changed 200 to 100, up: next enabled edge gives q0=0 with c_out[0]=1.
   - Same 150 state with dir=1: next enabled edge gives q0=99 with c_out[0]=0.
   - M0=0: q0=255 goes to 0 with carry.
   - M0=1: q0 stays 0 and c_out[0]=enable every cycle.

Source files
------------

// File: rtl/mod_counter_chain.sv
// mod_counter_chain: cascade of runtime-modulus up/down counters with per-stage carry and a registered full-chain wrap pulse
module mod_counter_chain #(
  parameter int N = 8,
  parameter int CH = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          load,
  input  logic          dir,
  input  logic [CH*N-1:0] modul,
  input  logic [CH*N-1:0] load_val,
  output logic [CH*N-1:0] q_out,
  output logic [CH-1:0]   c_out,
  output logic          wrap_out
);
  logic [CH*N-1:0] q_nxt;
  for (genvar g = 0; g < CH; g++) begin : stg
    logic adv, cy;
    logic [N-1:0] q, top;
    assign q = q_out[g*N +: N];
    assign top = modul[g*N +: N] - 1'b1;
    if (g == 0) begin : a0
      assign adv = enable & ~load;
    end else begin : an
      assign adv = stg[g-1].cy;
    end
    assign cy = adv & (dir ? q == '0 : q >= top) & reset & ~load;
    assign c_out[g] = cy;
    // Down-counting from an out-of-range value snaps to the new top without a borrow
    assign q_nxt[g*N +: N] = !adv ? q :
                             !dir ? (q >= top ? '0 : q + 1'b1) :
                             (q == '0 || q > top) ? top : q - 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_out <= '0;
      wrap_out <= 1'b0;
    end else begin
      q_out <= load ? load_val : q_nxt;
      wrap_out <= c_out[CH-1];
    end
  end
endmodule

// File: tb/tb_mod_counter_chain.sv
// tb_mod_counter_chain: directed vectors with a queued scoreboard checked by a negedge monitor
module tb_mod_counter_chain;
  localparam int N = 8;
  localparam int CH = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic load = 1'b0;
  logic dir = 1'b0;
  logic [CH*N-1:0] modul = '0;
  logic [CH*N-1:0] load_val = '0;
  logic [CH*N-1:0] q_out;
  logic [CH-1:0] c_out;
  logic wrap_out;
  typedef struct {
    string name;
    logic [N-1:0] q1;
    logic [N-1:0] q0;
    logic [1:0] c;
    logic w;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter_chain #(.N(N), .CH(CH)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(load),
    .dir(dir),
    .modul(modul),
    .load_val(load_val),
    .q_out(q_out),
    .c_out(c_out),
    .wrap_out(wrap_out)
  );

  function automatic void chk(string n, string f, logic [N-1:0] act, logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s actual=%0d expected=%0d at %0t", n, f, act, exp, $time);
    end
  endfunction

  // Each entry describes the cycle after the edge at which its inputs were applied
  task automatic step(input string name, input logic rst, input logic en, input logic ld,
                      input logic d, input logic [N-1:0] m1, input logic [N-1:0] m0,
                      input logic [N-1:0] lv1, input logic [N-1:0] lv0,
                      input logic [N-1:0] e1, input logic [N-1:0] e0,
                      input logic [1:0] ec, input logic ew);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst;
    enable = en;
    load = ld;
    dir = d;
    modul = {m1, m0};
    load_val = {lv1, lv0};
    e.name = name;
    e.q1 = e1;
    e.q0 = e0;
    e.c = ec;
    e.w = ew;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.name, "q0", q_out[N-1:0], e.q0);
      chk(e.name, "q1", q_out[2*N-1:N], e.q1);
      chk(e.name, "c_out", {6'd0, c_out}, {6'd0, e.c});
      chk(e.name, "wrap_out", {7'd0, wrap_out}, {7'd0, e.w});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 3; i++) step("reset_hold", 0, 1, 0, 0, 3, 5, 0, 0, 0, 0, 2'b00, 0);
    step("release", 1, 1, 0, 0, 3, 5, 0, 0, 0, 0, 2'b00, 0);
    step("release_adv", 1, 1, 0, 0, 3, 5, 0, 0, 0, 1, 2'b00, 0);
    step("reset_mid", 0, 1, 0, 0, 3, 5, 0, 0, 0, 2, 2'b00, 0);
    for (int i = 0; i <= 16; i++) begin
      logic c0, c1;
      c0 = (i % 5) == 4;
      c1 = c0 && ((i / 5) % 3) == 2;
      step("up_chain", 1, 1, 0, 0, 3, 5, 0, 0, 8'((i / 5) % 3), 8'(i % 5), {c1, c0}, i == 15);
    end
    step("reset_over_load", 0, 1, 1, 0, 3, 5, 1, 3, 0, 2, 2'b00, 0);
    for (int i = 0; i <= 16; i++) begin
      int p;
      logic c0, c1;
      p = (15 - (i % 15)) % 15;
      c0 = (p % 5) == 0;
      c1 = p == 0;
      step("down_chain", 1, 1, 0, 1, 3, 5, 0, 0, 8'(p / 5), 8'(p % 5), {c1, c0}, i == 1 || i == 16);
    end
    step("reset_gate", 0, 0, 0, 0, 3, 200, 0, 0, 2, 3, 2'b00, 0);
    begin
      int cnt;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
        logic en;
        en = ((i / 5) % 2) == 0;
        step("gated", 1, en, 0, 0, 3, 200, 0, 0, 0, 8'(cnt), 2'b00, 0);
        cnt += int'(en);
      end
    end
    step("load_198", 1, 1, 1, 0, 3, 200, 0, 198, 0, 10, 2'b00, 0);
    step("q0_198", 1, 1, 0, 0, 3, 200, 0, 0, 0, 198, 2'b00, 0);
    step("q0_199_carry", 1, 1, 0, 0, 3, 200, 0, 0, 0, 199, 2'b01, 0);
    step("q0_wrapped", 1, 0, 0, 0, 3, 200, 0, 0, 1, 0, 2'b00, 0);
    step("load_term", 1, 0, 1, 0, 3, 5, 2, 4, 1, 0, 2'b00, 0);
    step("load_priority", 1, 1, 1, 0, 3, 5, 1, 3, 2, 4, 2'b00, 0);
    step("load_result", 1, 0, 0, 0, 3, 5, 0, 0, 1, 3, 2'b00, 0);
    step("load_150_up", 1, 0, 1, 0, 3, 200, 0, 150, 1, 3, 2'b00, 0);
    step("mod_shrink_hold", 1, 0, 0, 0, 3, 100, 0, 0, 0, 150, 2'b00, 0);
    step("mod_shrink_up", 1, 1, 0, 0, 3, 100, 0, 0, 0, 150, 2'b01, 0);
    step("mod_shrink_up_res", 1, 0, 0, 0, 3, 100, 0, 0, 1, 0, 2'b00, 0);
    step("load_150_dn", 1, 0, 1, 1, 3, 100, 0, 150, 1, 0, 2'b00, 0);
    step("mod_shrink_dn", 1, 1, 0, 1, 3, 100, 0, 0, 0, 150, 2'b00, 0);
    step("mod_shrink_dn_res", 1, 0, 0, 1, 3, 100, 0, 0, 0, 99, 2'b00, 0);
    step("load_255", 1, 0, 1, 0, 3, 0, 0, 255, 0, 99, 2'b00, 0);
    step("full_range_carry", 1, 1, 0, 0, 3, 0, 0, 0, 0, 255, 2'b01, 0);
    step("full_range_wrap", 1, 0, 0, 0, 3, 0, 0, 0, 1, 0, 2'b00, 0);
    step("mod1_en", 1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 2'b01, 0);
    step("mod1_idle", 1, 0, 0, 0, 0, 1, 0, 0, 2, 0, 2'b00, 0);
    step("mod1_en2", 1, 1, 0, 0, 0, 1, 0, 0, 2, 0, 2'b01, 0);
    step("mod1_en3", 1, 1, 0, 0, 0, 1, 0, 0, 3, 0, 2'b01, 0);
    step("mod1_end", 1, 0, 0, 0, 0, 1, 0, 0, 4, 0, 2'b00, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
